// File: rtl/rggen_rtl_pkg.sv
// Shared types for rggen bus initiators and bridges: response status codes
// and the APB initiator state encoding.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY    = 2'b00,
        RGGEN_SLVERR  = 2'b10,
        RGGEN_TIMEOUT = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        APB_INIT_IDLE     = 2'd0,
        APB_INIT_SETUP    = 2'd1,
        APB_INIT_ACCESS   = 2'd2,
        APB_INIT_RESPONSE = 2'd3
    } rggen_apb_initiator_state;

endpackage

// File: rtl/rggen_apb_if.sv
// APB3/APB4 bus bundle shared by the initiator and generated register blocks.
interface rggen_apb_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    logic                       psel;
    logic                       penable;
    logic [ADDRESS_WIDTH-1:0]   paddr;
    logic [2:0]                 pprot;
    logic                       pwrite;
    logic [BUS_WIDTH/8-1:0]     pstrb;
    logic [BUS_WIDTH-1:0]       pwdata;
    logic                       pready;
    logic [BUS_WIDTH-1:0]       prdata;
    logic                       pslverr;

    modport master (
        output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/rggen_apb_initiator_timer.sv
// Clearable saturating counter of ACCESS wait cycles; flags when the count
// has reached TIMEOUT_CYCLES-1. Tied off when TIMEOUT_CYCLES is 0.
module rggen_apb_initiator_timer #(
    parameter int TIMEOUT_CYCLES = 256
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_timeout
);
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign o_timeout = 1'b0;
        end else begin : g_enabled
            localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (i_clear) begin
                    count_d = '0;
                end else if (i_count && (count_q != LAST)) begin
                    count_d = count_q + 1'b1;
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign o_timeout = (count_q == LAST);
        end
    endgenerate
endmodule

// File: rtl/rggen_apb_initiator.sv
// Valid/ready request/response to APB master bridge, one transfer in flight,
// with an optional ACCESS-phase timeout against slaves that never respond.
module rggen_apb_initiator
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
)(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_request_valid,
    output logic                      o_request_ready,
    input  logic                      i_request_write,
    input  logic [ADDRESS_WIDTH-1:0]  i_request_address,
    input  logic [BUS_WIDTH-1:0]      i_request_write_data,
    input  logic [BUS_WIDTH/8-1:0]    i_request_strobe,
    output logic                      o_response_valid,
    input  logic                      i_response_ready,
    output logic [BUS_WIDTH-1:0]      o_response_read_data,
    output logic [1:0]                o_response_status,
    rggen_apb_if.master               apb_if
);
    localparam int STRB_WIDTH = BUS_WIDTH / 8;

    rggen_apb_initiator_state state_q;
    rggen_apb_initiator_state state_d;

    logic                     write_q,      write_d;
    logic [ADDRESS_WIDTH-1:0] address_q,    address_d;
    logic [BUS_WIDTH-1:0]     write_data_q, write_data_d;
    logic [STRB_WIDTH-1:0]    strobe_q,     strobe_d;
    logic [BUS_WIDTH-1:0]     read_data_q,  read_data_d;
    rggen_status              status_q,     status_d;

    logic request_ready;
    logic psel;
    logic penable;
    logic response_valid;
    logic timer_clear;
    logic timer_count;
    logic timeout;

    rggen_apb_initiator_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (timer_clear),
        .i_count   (timer_count),
        .o_timeout (timeout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= APB_INIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // pready wins over a timeout landing on the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            APB_INIT_IDLE: begin
                if (i_request_valid) begin
                    state_d = APB_INIT_SETUP;
                end
            end
            APB_INIT_SETUP: begin
                state_d = APB_INIT_ACCESS;
            end
            APB_INIT_ACCESS: begin
                if (apb_if.pready || timeout) begin
                    state_d = APB_INIT_RESPONSE;
                end
            end
            APB_INIT_RESPONSE: begin
                if (i_response_ready) begin
                    state_d = APB_INIT_IDLE;
                end
            end
            default: state_d = APB_INIT_IDLE;
        endcase
    end

    always_comb begin
        request_ready  = 1'b0;
        psel           = 1'b0;
        penable        = 1'b0;
        response_valid = 1'b0;
        timer_clear    = 1'b0;
        timer_count    = 1'b0;
        case (state_q)
            APB_INIT_IDLE: begin
                request_ready = 1'b1;
            end
            APB_INIT_SETUP: begin
                psel        = 1'b1;
                timer_clear = 1'b1;
            end
            APB_INIT_ACCESS: begin
                psel        = 1'b1;
                penable     = 1'b1;
                timer_count = !apb_if.pready;
            end
            APB_INIT_RESPONSE: begin
                response_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        write_d      = write_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        strobe_d     = strobe_q;
        read_data_d  = read_data_q;
        status_d     = status_q;
        if ((state_q == APB_INIT_IDLE) && i_request_valid) begin
            write_d      = i_request_write;
            address_d    = i_request_address;
            write_data_d = i_request_write_data;
            strobe_d     = i_request_write ? i_request_strobe : '0;
        end
        if (state_q == APB_INIT_ACCESS) begin
            if (apb_if.pready) begin
                status_d    = apb_if.pslverr ? RGGEN_SLVERR : RGGEN_OKAY;
                read_data_d = write_q ? '0 : apb_if.prdata;
            end else if (timeout) begin
                status_d    = RGGEN_TIMEOUT;
                read_data_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            write_q      <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            strobe_q     <= '0;
            read_data_q  <= '0;
            status_q     <= RGGEN_OKAY;
        end else begin
            write_q      <= write_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            strobe_q     <= strobe_d;
            read_data_q  <= read_data_d;
            status_q     <= status_d;
        end
    end

    assign o_request_ready      = request_ready;
    assign o_response_valid     = response_valid;
    assign o_response_read_data = read_data_q;
    assign o_response_status    = status_q;

    assign apb_if.psel    = psel;
    assign apb_if.penable = penable;
    assign apb_if.paddr   = address_q;
    assign apb_if.pprot   = 3'b000;
    assign apb_if.pwrite  = write_q;
    assign apb_if.pstrb   = strobe_q;
    assign apb_if.pwdata  = write_data_q;
endmodule

// File: tb/tb_rggen_apb_initiator.sv
// Directed self-checking bench for rggen_apb_initiator with TIMEOUT_CYCLES=8;
// the bench plays the APB slave by driving pready/prdata/pslverr directly.
module tb_rggen_apb_initiator;
    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_status;

    int checks = 0;
    int errors = 0;

    rggen_apb_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) apb_if ();

    rggen_apb_initiator #(
        .ADDRESS_WIDTH  (AW),
        .BUS_WIDTH      (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_request_valid      (req_valid),
        .o_request_ready      (req_ready),
        .i_request_write      (req_write),
        .i_request_address    (req_addr),
        .i_request_write_data (req_wdata),
        .i_request_strobe     (req_strb),
        .o_response_valid     (rsp_valid),
        .i_response_ready     (rsp_ready),
        .o_response_read_data (rsp_rdata),
        .o_response_status    (rsp_status),
        .apb_if               (apb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [3:0] s);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++;
        if ({apb_if.psel, apb_if.penable, apb_if.pwrite} !== 3'b000) begin
            errors++; $display("FAIL reset_apb_ctrl: got %b expected 000", {apb_if.psel, apb_if.penable, apb_if.pwrite});
        end
        checks++;
        if ({apb_if.paddr, apb_if.pstrb, apb_if.pwdata} !== '0) begin
            errors++; $display("FAIL reset_apb_data: got addr=%h strb=%h wdata=%h expected 0", apb_if.paddr, apb_if.pstrb, apb_if.pwdata);
        end
        checks++;
        if ({rsp_rdata, rsp_status} !== '0) begin
            errors++; $display("FAIL reset_rsp: got data=%h status=%b expected 0/00", rsp_rdata, rsp_status);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("txn reset done");
    endtask

    task automatic test_write_zero_wait();
        apb_if.pready = 1'b1;
        rsp_ready     = 1'b1;
        set_req(1'b1, 16'h0010, 32'hA5A5_00FF, 4'hF);
        tick();
        req_valid = 1'b0;
        checks++;
        if ({apb_if.psel, apb_if.penable} !== 2'b10) begin
            errors++; $display("FAIL wr_setup: got psel/penable=%b expected 10", {apb_if.psel, apb_if.penable});
        end
        checks++;
        if ({apb_if.pwrite, apb_if.pstrb, apb_if.paddr, apb_if.pwdata} !== {1'b1, 4'hF, 16'h0010, 32'hA5A5_00FF}) begin
            errors++; $display("FAIL wr_bus: got w=%b strb=%h addr=%h data=%h expected 1/f/0010/a5a500ff",
                               apb_if.pwrite, apb_if.pstrb, apb_if.paddr, apb_if.pwdata);
        end
        tick();
        checks++;
        if ({apb_if.psel, apb_if.penable, rsp_valid} !== 3'b110) begin
            errors++; $display("FAIL wr_access: got psel/penable/rsp_valid=%b expected 110", {apb_if.psel, apb_if.penable, rsp_valid});
        end
        tick();
        checks++;
        if ({rsp_valid, apb_if.psel, rsp_status, rsp_rdata} !== {1'b1, 1'b0, 2'b00, 32'h0}) begin
            errors++; $display("FAIL wr_response: got valid=%b psel=%b status=%b data=%h expected 1/0/00/0",
                               rsp_valid, apb_if.psel, rsp_status, rsp_rdata);
        end
        tick();
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++; $display("FAIL wr_idle: got rsp_valid/req_ready=%b expected 01", {rsp_valid, req_ready});
        end
        $display("txn write addr=0010 data=a5a500ff status=%b", rsp_status);
    endtask

    task automatic test_read_wait3();
        apb_if.pready = 1'b0;
        apb_if.prdata = 32'h1234_5678;
        set_req(1'b0, 16'h0020, 32'hFFFF_FFFF, 4'hF);
        tick();
        req_valid = 1'b0;
        checks++;
        if ({apb_if.psel, apb_if.pwrite, apb_if.pstrb} !== {1'b1, 1'b0, 4'h0}) begin
            errors++; $display("FAIL rd_setup: got psel=%b w=%b strb=%h expected 1/0/0", apb_if.psel, apb_if.pwrite, apb_if.pstrb);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({apb_if.psel, apb_if.penable, rsp_valid, apb_if.paddr} !== {3'b110, 16'h0020}) begin
                errors++; $display("FAIL rd_wait%0d: got psel/penable/rsp=%b addr=%h expected 110/0020",
                                   i, {apb_if.psel, apb_if.penable, rsp_valid}, apb_if.paddr);
            end
        end
        apb_if.pready = 1'b1;
        tick();
        apb_if.pready = 1'b0;
        checks++;
        if ({rsp_valid, rsp_status, rsp_rdata} !== {1'b1, 2'b00, 32'h1234_5678}) begin
            errors++; $display("FAIL rd_response: got valid=%b status=%b data=%h expected 1/00/12345678",
                               rsp_valid, rsp_status, rsp_rdata);
        end
        tick();
        $display("txn read addr=0020 waits=3 data=%h status=%b", rsp_rdata, rsp_status);
    endtask

    task automatic test_slverr();
        apb_if.pready  = 1'b0;
        apb_if.prdata  = 32'hDEAD_BEEF;
        apb_if.pslverr = 1'b1;
        set_req(1'b0, 16'h0044, 32'h0, 4'h0);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({apb_if.penable, apb_if.paddr} !== {1'b1, 16'h0044}) begin
            errors++; $display("FAIL slverr_hold: got penable=%b addr=%h expected 1/0044", apb_if.penable, apb_if.paddr);
        end
        apb_if.pready = 1'b1;
        tick();
        apb_if.pready  = 1'b0;
        apb_if.pslverr = 1'b0;
        checks++;
        if ({rsp_valid, rsp_status, rsp_rdata} !== {1'b1, 2'b10, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL slverr_response: got valid=%b status=%b data=%h expected 1/10/deadbeef",
                               rsp_valid, rsp_status, rsp_rdata);
        end
        tick();
        $display("txn read addr=0044 status=%b", rsp_status);
    endtask

    task automatic test_timeout(input logic ready_on_last);
        apb_if.pready = 1'b0;
        apb_if.prdata = 32'hCAFE_0001;
        set_req(1'b0, 16'h0030, 32'h0, 4'h0);
        tick();
        req_valid = 1'b0;
        tick();
        for (int k = 1; k < 8; k++) begin
            tick();
            checks++;
            if ({apb_if.psel, apb_if.penable, rsp_valid} !== 3'b110) begin
                errors++; $display("FAIL timeout_wait%0d: got psel/penable/rsp=%b expected 110",
                                   k, {apb_if.psel, apb_if.penable, rsp_valid});
            end
        end
        apb_if.pready = ready_on_last;
        tick();
        apb_if.pready = 1'b0;
        checks++;
        if (ready_on_last) begin
            if ({rsp_valid, apb_if.psel, rsp_status, rsp_rdata} !== {2'b10, 2'b00, 32'hCAFE_0001}) begin
                errors++; $display("FAIL timeout_ready_wins: got valid=%b psel=%b status=%b data=%h expected 1/0/00/cafe0001",
                                   rsp_valid, apb_if.psel, rsp_status, rsp_rdata);
            end
        end else begin
            if ({rsp_valid, apb_if.psel, rsp_status, rsp_rdata} !== {2'b10, 2'b11, 32'h0}) begin
                errors++; $display("FAIL timeout_abort: got valid=%b psel=%b status=%b data=%h expected 1/0/11/0",
                                   rsp_valid, apb_if.psel, rsp_status, rsp_rdata);
            end
        end
        tick();
        $display("txn read addr=0030 ready_on_8th=%b status=%b", ready_on_last, rsp_status);
    endtask

    task automatic test_back_to_back();
        apb_if.pready = 1'b1;
        apb_if.prdata = 32'h0BAD_F00D;
        rsp_ready     = 1'b0;
        set_req(1'b0, 16'h0050, 32'h0, 4'h0);
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, req_ready, apb_if.psel, rsp_rdata} !== {3'b100, 32'h0BAD_F00D}) begin
                errors++; $display("FAIL backpressure%0d: got rsp/req_ready/psel=%b data=%h expected 100/0badf00d",
                                   i, {rsp_valid, req_ready, apb_if.psel}, rsp_rdata);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, req_ready, apb_if.psel} !== 3'b010) begin
            errors++; $display("FAIL b2b_handshake: got rsp/req_ready/psel=%b expected 010", {rsp_valid, req_ready, apb_if.psel});
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if ({apb_if.psel, req_ready} !== 2'b10) begin
            errors++; $display("FAIL b2b_accept: got psel/req_ready=%b expected 10", {apb_if.psel, req_ready});
        end
        repeat (3) tick();
        $display("txn backpressure read addr=0050 data=%h", rsp_rdata);
    endtask

    task automatic test_reset_mid();
        apb_if.pready = 1'b0;
        set_req(1'b1, 16'h00F0, 32'h1111_2222, 4'h3);
        tick();
        req_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({apb_if.psel, apb_if.penable, req_ready, rsp_valid} !== 4'b0010) begin
            errors++; $display("FAIL midreset_ctrl: got psel/penable/req_ready/rsp=%b expected 0010",
                               {apb_if.psel, apb_if.penable, req_ready, rsp_valid});
        end
        checks++;
        if ({apb_if.paddr, apb_if.pstrb, apb_if.pwdata, apb_if.pwrite} !== '0) begin
            errors++; $display("FAIL midreset_bus: got addr=%h strb=%h data=%h w=%b expected 0",
                               apb_if.paddr, apb_if.pstrb, apb_if.pwdata, apb_if.pwrite);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        apb_if.pready = 1'b1;
        apb_if.prdata = 32'h7777_0000;
        set_req(1'b0, 16'h0060, 32'h0, 4'h0);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_status, rsp_rdata} !== {1'b1, 2'b00, 32'h7777_0000}) begin
            errors++; $display("FAIL midreset_recover: got valid=%b status=%b data=%h expected 1/00/77770000",
                               rsp_valid, rsp_status, rsp_rdata);
        end
        tick();
        $display("txn read after reset addr=0060 data=%h", rsp_rdata);
    endtask

    initial begin
        req_valid      = 1'b0;
        req_write      = 1'b0;
        req_addr       = '0;
        req_wdata      = '0;
        req_strb       = '0;
        rsp_ready      = 1'b1;
        apb_if.pready  = 1'b0;
        apb_if.prdata  = '0;
        apb_if.pslverr = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_wait3();
        test_slverr();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
